mem_tag_responder: RTL

Tagged memory responder on the processor↔memory interface. It is the responder that the load queue talks to.
- Accepts one LOAD or STORE command per cycle.
- Grants each accepted LOAD a nonzero 4-bit transaction tag in the same cycle.
- After a fixed latency, broadcasts that tag together with the load data, so the waiting load-queue entry can match it.
- Owns a small word-addressed backing store, and the tag free list / in-flight pipeline.

---
 rtl/mem_tag_responder.sv | 89 ++++++++
 1 files changed

// File: rtl/mem_tag_responder.sv
// mem_tag_responder: tagged load/store responder with a fixed-latency load pipeline and tag free list
module mem_tag_responder #(
    parameter int MEM_LATENCY = 4,
    parameter int NUM_TAGS    = 15,
    parameter int MEM_WORDS   = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  proc2mem_command,
    input  logic [63:0] proc2mem_addr,
    input  logic [63:0] proc2mem_data,
    output logic [3:0]  mem2proc_response,
    output logic        store_ack,
    output logic [3:0]  mem2proc_tag,
    output logic [63:0] mem2proc_data,
    output logic [3:0]  outstanding
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [NUM_TAGS:1] free_mask;
    logic [NUM_TAGS:1] free_next;
    logic              pipe_valid [MEM_LATENCY];
    logic [3:0]        pipe_tag   [MEM_LATENCY];
    logic [63:0]       pipe_data  [MEM_LATENCY];
    logic [63:0]       mem        [MEM_WORDS];
    logic [AW-1:0]     idx;
    logic [3:0]        grant;
    logic [3:0]        done_tag;
    logic              accept;
    logic              done;

    assign idx               = proc2mem_addr[3 +: AW];
    assign accept            = !reset && proc2mem_command == 2'b01 && |free_mask;
    assign store_ack         = !reset && proc2mem_command == 2'b10;
    assign done              = pipe_valid[MEM_LATENCY-1];
    assign done_tag          = pipe_tag[MEM_LATENCY-1];
    assign mem2proc_response = accept ? grant : 4'd0;
    assign mem2proc_tag      = done ? done_tag : 4'd0;
    assign mem2proc_data     = done ? pipe_data[MEM_LATENCY-1] : 64'd0;

    // Lowest free tag is granted; the grant clear and completion set land on the same edge.
    always_comb begin
        grant     = 4'd0;
        free_next = free_mask;
        for (int i = NUM_TAGS; i >= 1; i--) begin
            if (free_mask[i]) grant = 4'(i);
        end
        for (int i = 1; i <= NUM_TAGS; i++) begin
            if (accept && grant == 4'(i)) free_next[i] = 1'b0;
            if (done && done_tag == 4'(i)) free_next[i] = 1'b1;
        end
    end

    // Free list and in-flight count.
    always_ff @(posedge clock) begin
        if (reset) begin
            free_mask   <= '1;
            outstanding <= 4'd0;
        end else begin
            free_mask   <= free_next;
            outstanding <= outstanding + 4'(accept) - 4'(done);
        end
    end

    // Load pipeline; data is captured at acceptance so later stores cannot alter it.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MEM_LATENCY; i++) pipe_valid[i] <= 1'b0;
        end else begin
            pipe_valid[0] <= accept;
            for (int i = 1; i < MEM_LATENCY; i++) pipe_valid[i] <= pipe_valid[i-1];
        end
        pipe_tag[0]  <= grant;
        pipe_data[0] <= mem[idx];
        for (int i = 1; i < MEM_LATENCY; i++) begin
            pipe_tag[i]  <= pipe_tag[i-1];
            pipe_data[i] <= pipe_data[i-1];
        end
    end

    // Backing store, cleared on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= 64'd0;
        end else if (store_ack) begin
            mem[idx] <= proc2mem_data;
        end
    end
endmodule
